// File: rtl/aes10_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes10_pkg
//  Description : Shared definitions for the 10-bit toy block decryptor:
//                default round count, FSM state encoding, the inverse bit
//                permutation and the two Feistel mixing functions used by
//                the 10-bit S-box pair.
//  Revision    : 1.0 - initial release
// ============================================================================
package aes10_pkg;

   localparam int ROUNDS_DEFAULT = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      DONE  = 2'd2
   } fsm_e;

   // The encryptor permutation moves input bit (3*i+1) mod 10 to output
   // bit i. This is its inverse: input bit i returns to position
   // (3*i+1) mod 10. Written out as a flat concatenation.
   function automatic logic [9:0] inv_perm10(input logic [9:0] x);
      return {x[6], x[9], x[2], x[5], x[8], x[1], x[4], x[7], x[0], x[3]};
   endfunction

   // Round function applied to the right half to mask the left half.
   function automatic logic [4:0] sbox_f(input logic [4:0] r);
      return {r[3:0], r[4]} ^ ({r[2:0], r[4:3]} & ~{r[1:0], r[4:2]}) ^ 5'h0B;
   endfunction

   // Round function applied to the new left half to mask the right half.
   function automatic logic [4:0] sbox_g(input logic [4:0] l);
      return {l[0], l[4:1]} ^ (l & {l[2:0], l[4:3]}) ^ 5'h14;
   endfunction

endpackage
`default_nettype wire

// File: rtl/aes10_inv_sbox10.sv
`default_nettype none
// ============================================================================
//  Module      : inv_sbox10
//  Description : Combinational inverse of the 10-bit S-box. The forward
//                S-box is a two-step Feistel network on 5-bit halves
//                (L' = L ^ f(R), R' = R ^ g(L')), so the inverse undoes
//                the steps in reverse order.
//  Revision    : 1.0 - initial release
// ============================================================================
module inv_sbox10
   import aes10_pkg::*;
(
   input  logic [9:0] y_i,
   output logic [9:0] x_o
);

   logic [4:0] w_right;
   logic [4:0] w_left;

   // Undo the right-half mask first, then the left-half mask.
   always_comb begin
      w_right = y_i[4:0] ^ sbox_g(y_i[9:5]);
      w_left  = y_i[9:5] ^ sbox_f(w_right);
      x_o     = {w_left, w_right};
   end

endmodule
`default_nettype wire

// File: rtl/aes10_dec.sv
`default_nettype none
// ============================================================================
//  Module      : aes10_dec
//  Description : Iterative 10-bit toy block decryptor. An accepted start
//                captures ciphertext and key, ROUNDS inverse rounds are
//                applied one per clock, and one further edge registers the
//                result onto plaintext with ready. Fixed latency ROUNDS+1.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes10_dec
   import aes10_pkg::*;
#(
   parameter int ROUNDS = ROUNDS_DEFAULT
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [9:0] ciphertext,
   input  logic [9:0] key,
   output logic [9:0] plaintext,
   output logic       ready,
   output logic       busy
);

   // The counter stops at ROUNDS; that edge moves the result to the output
   // register, giving the fixed ROUNDS+1 latency without a fourth state.
   localparam logic [2:0] C_LAST_ROUND = 3'(ROUNDS);

   fsm_e       fsm_q;
   logic [9:0] data_q;
   logic [9:0] key_q;
   logic [2:0] round_q;
   logic [9:0] plaintext_q;
   logic       ready_q;
   logic       busy_q;

   logic [9:0] mix_d;
   logic [9:0] data_d;

   // One inverse round: remove key, undo permutation, undo S-box.
   always_comb begin
      mix_d = inv_perm10(data_q ^ key_q);
   end

   inv_sbox10 u_inv_sbox (
      .y_i (mix_d),
      .x_o (data_d)
   );

   // Control FSM with datapath and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fsm_q       <= IDLE;
         data_q      <= '0;
         key_q       <= '0;
         round_q     <= '0;
         plaintext_q <= '0;
         ready_q     <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (fsm_q)
            IDLE, DONE: begin
               if (start) begin
                  data_q  <= ciphertext;
                  key_q   <= key;
                  round_q <= '0;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
                  fsm_q   <= ROUND;
               end
            end
            ROUND: begin
               // start is deliberately ignored here.
               if (round_q == C_LAST_ROUND) begin
                  plaintext_q <= data_q;
                  ready_q     <= 1'b1;
                  busy_q      <= 1'b0;
                  fsm_q       <= DONE;
               end else begin
                  data_q  <= data_d;
                  round_q <= round_q + 3'd1;
               end
            end
            default: begin
               fsm_q <= IDLE;
            end
         endcase
      end
   end

   assign plaintext = plaintext_q;
   assign ready     = ready_q;
   assign busy      = busy_q;

endmodule
`default_nettype wire
